// File: rtl/h14tx_island_sched_if.sv
// Scheduler-side bundle: line timing and packet requests in, period
// sequence and grants out toward the TMDS encoder and packet sources.
interface h14tx_island_sched_if #(
  parameter int NumReq = 4
);
  localparam int SelW = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic              de;
  logic [11:0]       blank_len;
  logic [NumReq-1:0] req;
  logic [NumReq-1:0] grant;
  logic [SelW-1:0]   pkt_sel;
  logic [4:0]        pkt_word;
  logic [1:0]        period;
  logic              island_active;

  // Timing generator / packet sources side
  modport master (
    output de, blank_len, req,
    input  grant, pkt_sel, pkt_word, period, island_active
  );

  // Scheduler side
  modport slave (
    input  de, blank_len, req,
    output grant, pkt_sel, pkt_word, period, island_active
  );
endinterface

// File: rtl/h14tx_island_sched.sv
// Data-island scheduler: per blanking interval decides how many 32-pixel
// packets fit, grants requesters round-robin and sequences the periods.
//
// state      | meaning
// S_IDLE     | active video, waiting for the de falling edge
// S_WAIT     | blanking, counting down to the preamble start pixel
// S_PREAMBLE | 8 preamble pixels
// S_LGUARD   | 2 leading guard-band pixels
// S_DATA     | 32 pixels per packet, n packets back to back
// S_TGUARD   | 2 trailing guard-band pixels
// S_DONE     | rest of blanking in CTRL, waiting for de
module h14tx_island_sched #(
  parameter int NumReq      = 4,
  parameter int MaxPackets  = 2,
  parameter int IslandStart = 10,
  parameter int MinTail     = 12
) (
  input  logic                 i_pixel_clk,
  input  logic                 i_rst,
  h14tx_island_sched_if.slave  bus
);
  localparam int SelW = (NumReq > 1) ? $clog2(NumReq) : 1;
  // preamble + both guard pairs = 12 pixels of island overhead
  localparam logic signed [12:0] FitOffset = 13'(IslandStart + 12 + MinTail);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_PREAMBLE, S_LGUARD, S_DATA, S_TGUARD, S_DONE
  } state_t;

  state_t              r_state, w_state;
  logic                r_de_q;
  logic [11:0]         r_tmr, w_tmr;
  logic [4:0]          r_pkt_left, w_pkt_left;
  logic [NumReq-1:0]   r_pend, w_pend;
  logic [SelW-1:0]     r_rr_ptr, w_rr_ptr;
  logic [NumReq-1:0]   r_grant, w_grant;
  logic [SelW-1:0]     r_pkt_sel, w_pkt_sel;
  logic [4:0]          r_pkt_word, w_pkt_word;
  logic [1:0]          r_period, w_period;
  logic                r_island, w_island;

  logic                w_fall;
  logic                w_new_pkt;
  logic signed [12:0]  w_fit_raw;
  logic [6:0]          w_fit;
  logic [3:0]          w_pop;
  logic [7:0]          w_n;
  logic [NumReq-1:0]   w_rot;
  logic [SelW-1:0]     w_off;
  logic [SelW:0]       w_sum;
  logic [SelW-1:0]     w_sel;
  logic [SelW-1:0]     w_rr_inc;

  assign w_fall    = !bus.de && r_de_q;
  assign w_fit_raw = $signed({1'b0, bus.blank_len}) - FitOffset;
  assign w_fit     = w_fit_raw[12] ? 7'd0 : 7'(w_fit_raw >>> 5);

  // Count requests present at the snapshot pixel
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NumReq; i++) w_pop = w_pop + {3'b000, bus.req[i]};
  end

  // Packets this line: min(requests, MaxPackets, what fits before the tail)
  always_comb begin
    w_n = {4'b0000, w_pop};
    if (w_n > 8'(MaxPackets)) w_n = 8'(MaxPackets);
    if (w_n > {1'b0, w_fit})  w_n = {1'b0, w_fit};
  end

  // Round-robin pick: first pending bit at or after rr_ptr, with wrap
  assign w_rot = NumReq'({r_pend, r_pend} >> r_rr_ptr);
  always_comb begin
    w_off = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = SelW'(i);
    end
  end
  assign w_sum    = {1'b0, r_rr_ptr} + {1'b0, w_off};
  assign w_sel    = (w_sum >= (SelW+1)'(NumReq)) ? SelW'(w_sum - (SelW+1)'(NumReq))
                                                 : SelW'(w_sum);
  assign w_rr_inc = (w_sel == SelW'(NumReq - 1)) ? '0 : w_sel + SelW'(1);

  // Next state, phase timer and the registered output values
  always_comb begin
    w_state    = r_state;
    w_tmr      = r_tmr;
    w_pkt_left = r_pkt_left;
    w_pend     = r_pend;
    w_new_pkt  = 1'b0;
    w_rr_ptr   = r_rr_ptr;
    w_grant    = '0;
    w_pkt_sel  = r_pkt_sel;
    w_pkt_word = '0;
    w_period   = 2'd0;
    w_island   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_pend     = bus.req;
          w_pkt_left = w_n[4:0] - 5'd1;
          if (w_n == 8'd0) begin
            w_state = S_DONE;
          end else if (IslandStart == 0) begin
            w_state = S_PREAMBLE;
            w_tmr   = 12'd7;
          end else begin
            w_state = S_WAIT;
            w_tmr   = 12'(IslandStart - 1);
          end
        end
      end
      S_WAIT: begin
        if (r_tmr == '0) begin
          w_state = S_PREAMBLE;
          w_tmr   = 12'd7;
        end else w_tmr = r_tmr - 12'd1;
      end
      S_PREAMBLE: begin
        if (r_tmr == '0) begin
          w_state = S_LGUARD;
          w_tmr   = 12'd1;
        end else w_tmr = r_tmr - 12'd1;
      end
      S_LGUARD: begin
        if (r_tmr == '0) begin
          w_state   = S_DATA;
          w_tmr     = 12'd31;
          w_new_pkt = 1'b1;
        end else w_tmr = r_tmr - 12'd1;
      end
      S_DATA: begin
        if (r_tmr == '0) begin
          if (r_pkt_left == '0) begin
            w_state = S_TGUARD;
            w_tmr   = 12'd1;
          end else begin
            w_pkt_left = r_pkt_left - 5'd1;
            w_tmr      = 12'd31;
            w_new_pkt  = 1'b1;
          end
        end else w_tmr = r_tmr - 12'd1;
      end
      S_TGUARD: begin
        if (r_tmr == '0) w_state = S_DONE;
        else             w_tmr   = r_tmr - 12'd1;
      end
      S_DONE: begin
        if (bus.de) w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase

    // de high mid-island aborts the line; nothing more is granted
    if (bus.de) begin
      w_state   = S_IDLE;
      w_new_pkt = 1'b0;
    end

    if (w_new_pkt) begin
      w_grant   = NumReq'(1) << w_sel;
      w_pend    = w_pend & ~w_grant;
      w_rr_ptr  = w_rr_inc;
      w_pkt_sel = w_sel;
    end

    case (w_state)
      S_PREAMBLE: begin w_period = 2'd1; w_island = 1'b1; end
      S_LGUARD:   begin w_period = 2'd2; w_island = 1'b1; end
      S_DATA:     begin w_period = 2'd3; w_island = 1'b1; end
      S_TGUARD:   begin w_period = 2'd2; w_island = 1'b1; end
      default:    begin w_period = 2'd0; w_island = 1'b0; end
    endcase
    if (w_state == S_DATA) w_pkt_word = 5'd31 - w_tmr[4:0];
  end

  // State, line bookkeeping and output registers
  always_ff @(posedge i_pixel_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_de_q     <= 1'b0;
      r_tmr      <= '0;
      r_pkt_left <= '0;
      r_pend     <= '0;
      r_rr_ptr   <= '0;
      r_grant    <= '0;
      r_pkt_sel  <= '0;
      r_pkt_word <= '0;
      r_period   <= 2'd0;
      r_island   <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_de_q     <= bus.de;
      r_tmr      <= w_tmr;
      r_pkt_left <= w_pkt_left;
      r_pend     <= w_pend;
      r_rr_ptr   <= w_rr_ptr;
      r_grant    <= w_grant;
      r_pkt_sel  <= w_pkt_sel;
      r_pkt_word <= w_pkt_word;
      r_period   <= w_period;
      r_island   <= w_island;
    end
  end

  assign bus.grant         = r_grant;
  assign bus.pkt_sel       = r_pkt_sel;
  assign bus.pkt_word      = r_pkt_word;
  assign bus.period        = r_period;
  assign bus.island_active = r_island;
endmodule

// File: doc/h14tx_island_sched.md
# h14tx_island_sched

Data-island scheduler for the HDMI 1.4 transmitter. It runs in the pixel clock domain beside the timing generator. At each horizontal blanking interval it decides how many 32-pixel packets fit. It arbitrates round-robin among packet requesters, such as InfoFrame and audio sources, and drives the period sequence (control, preamble, guard band, packet data) that the TMDS encoder stage consumes.

## Interface

Parameters:
- `NumReq`, default 4: number of packet requesters (2..8).
- `MaxPackets`, default 2: maximum packets per data island (1..18).
- `IslandStart`, default 10: blanking pixel index where the preamble begins (≥ 0).
- `MinTail`, default 12: pixels that must remain between trailing guard end and active video.

Ports:
- `pixel_clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `de` in 1: data enable from the timing generator; 1 = active video.
- `blank_len` in 12: blanking pixels in the current line; must be stable from `de` fall until `de` rise.
- `req` in `NumReq`: level requests; a requester holds its bit until granted.
- `grant` out `NumReq`: one-hot, single-cycle grant pulse.
- `pkt_sel` out `$clog2(NumReq)`: index of the requester whose packet is being sent.
- `pkt_word` out 5: pixel index 0..31 within the current packet.
- `period` out 2: 0 = CTRL, 1 = DI_PREAMBLE, 2 = DI_GUARD, 3 = DI_DATA.
- `island_active` out 1: high from the first preamble pixel through the last trailing-guard pixel.

## Operation

- The blanking index `b` is 0 at the first cycle `de` is sampled 0 after being 1. It increments each cycle while `de` = 0.
- At b = 0, the block snapshots `req` into `pend`.
- At b = 0, it computes `n = min(popcount(pend), MaxPackets, fit)`.
  - `fit = floor((blank_len − IslandStart − 12 − MinTail) / 32)`.
  - `fit` is computed in 13-bit signed arithmetic; a negative result gives 0.
- If n = 0, no island is sent and `period` stays CTRL for the whole line.
- State machine: IDLE → WAIT → PREAMBLE → LGUARD → DATA → TGUARD → DONE → IDLE.
  - IDLE: waits for a `de` falling edge. On that edge it goes to WAIT if n > 0, else to DONE.
  - WAIT: transitions to PREAMBLE at b = IslandStart.
  - PREAMBLE: lasts 8 pixels.
  - LGUARD: lasts 2 pixels.
  - DATA: lasts 32·n pixels.
  - TGUARD: lasts 2 pixels.
  - DONE: holds until `de` = 1, then goes to IDLE.
- At `pkt_word` = 0 of each packet, the block selects the first set bit of `pend` at or after `rr_ptr`, wrapping modulo `NumReq`.
  - It pulses `grant` for that bit, clears the bit in `pend`, and sets `rr_ptr` to selected+1 (mod `NumReq`).
  - `pkt_sel` then holds the selected index for 32 cycles.
- `rr_ptr` persists across lines. It resets to 0.
- Requests raised after the b = 0 snapshot wait for the next line. Ungranted snapshot bits are not carried over; they are re-sampled from `req` on the next line.
- If `de` rises in any state other than IDLE or DONE, the line is aborted:
  - The block goes to IDLE with `period` = CTRL.
  - No further grants are issued on that line.
  - `rr_ptr` keeps the value from the grants already issued.
- If reset is released while `de` = 0, the block waits in IDLE for the next falling edge.

## Timing

- All outputs are registered. The outputs describing blanking pixel b appear in the cycle after `de` is sampled low for pixel b (1-cycle latency).
- For the island starting at b = S = IslandStart:
  - PREAMBLE covers pixels S..S+7.
  - LGUARD covers S+8..S+9.
  - Packet k (0-based) covers S+10+32k .. S+41+32k.
  - TGUARD covers S+10+32n .. S+11+32n.
- The `grant` pulse coincides with `pkt_word` = 0 of its packet.
- The decision (n, `pend`) is taken at b = 0 and does not change for the rest of the line.
- Reset values:
  - `grant` = 0, `pkt_sel` = 0, `pkt_word` = 0.
  - `period` = CTRL (0), `island_active` = 0.
  - State = IDLE, `rr_ptr` = 0, `pend` = 0.
- Outside DATA, `pkt_word` is 0.

## Test plan

Default parameters are used throughout.

- 720p line, `blank_len` = 370, `req` = 4'b0001:
  - PREAMBLE at b = 10..17, GUARD at 18..19, DATA at 20..51, GUARD at 52..53, then CTRL.
  - `grant` = 0001 at b = 20; `pkt_word` counts 0..31.
- All four requesters held for 3 lines at `blank_len` = 370:
  - Grants go 0, 1 / 2, 3 / 0, 1.
  - The two grants in a line are 32 cycles apart.
- `blank_len` = 70 with `req` = 0011: n = 1, only requester 0 is granted. With `req` held, requester 1 is granted on the next line.
- `blank_len` = 60 with `req` = 1111: no island, `period` = CTRL all line, no grants.
- `blank_len` = 370 with `req` = 0110, `de` forced high at b = 30: `period` = CTRL the next cycle, no grant for requester 2, `rr_ptr` = 2.
- `rst` asserted mid-DATA: all outputs reach reset values immediately (asynchronously). After release with `de` = 0, no island is sent until the next `de` fall.
